// File: rtl/llapi_device.sv
// llapi_device: controller-side responder for the LLAPI serial link.
// Acknowledges host polls and shifts out a 112-bit TYPE/BUTTONS/ANALOG frame, MSB first.
module llapi_device #(
  parameter int START_MIN = 100,
  parameter int TIMEOUT   = 5000
) (
  input  logic        CLK_50M,
  input  logic        RST_N,
  input  logic        ENABLE,
  input  logic        IO_LATCH_IN,
  output logic        IO_DATA_OUT,
  input  logic [7:0]  DEV_TYPE,
  input  logic [31:0] DEV_BUTTONS,
  input  logic [71:0] DEV_ANALOG,
  output logic        ACTIVE,
  output logic        FRAME_DONE,
  output logic        FRAME_ABORT
);
  typedef enum logic [2:0] {S_IDLE, S_START, S_ACK, S_SHIFT, S_DONE} state_t;

  localparam logic [15:0] LO_LAST  = 16'(START_MIN - 1);
  localparam logic [15:0] HI_LAST  = 16'(TIMEOUT - 1);
  localparam logic [6:0]  LAST_BIT = 7'd111;

  logic [1:0]   rst_sync;
  logic         rst_n_i;
  logic         latch_p0, latch_s, latch_d;
  logic         fall, rise, lo_hit, hi_hit;
  logic [15:0]  lo_cnt, hi_cnt;
  logic [111:0] shreg;
  logic [6:0]   bit_idx;
  logic         data_q, data_nxt, abort_q, load, shift;
  state_t       state, state_nxt;

  always_ff @(posedge CLK_50M or negedge RST_N)
    if (!RST_N) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};

  assign rst_n_i = rst_sync[1];

  // Stage p0 -> s: pin synchroniser; latch_d keeps the previous latch_s for edge detection
  always_ff @(posedge CLK_50M or negedge rst_n_i)
    if (!rst_n_i) begin
      latch_p0 <= 1'b1;
      latch_s  <= 1'b1;
      latch_d  <= 1'b1;
    end else begin
      latch_p0 <= IO_LATCH_IN;
      latch_s  <= latch_p0;
      latch_d  <= latch_s;
    end

  assign fall   = latch_d & ~latch_s;
  assign rise   = ~latch_d & latch_s;
  // Hits fire on the clock whose count reaches the threshold
  assign lo_hit = ~latch_s & (lo_cnt == LO_LAST);
  assign hi_hit = latch_s & (hi_cnt == HI_LAST);

  always_ff @(posedge CLK_50M or negedge rst_n_i)
    if (!rst_n_i) begin
      lo_cnt <= '0;
      hi_cnt <= '0;
    end else begin
      if (latch_s)                  lo_cnt <= '0;
      else if (lo_cnt != 16'hFFFF)  lo_cnt <= lo_cnt + 16'd1;
      if (state != S_SHIFT || !latch_s) hi_cnt <= '0;
      else if (hi_cnt != 16'hFFFF)      hi_cnt <= hi_cnt + 16'd1;
    end

  always_ff @(posedge CLK_50M or negedge rst_n_i)
    if (!rst_n_i) state <= S_IDLE;
    else          state <= state_nxt;

  always_comb begin
    state_nxt = state;
    if (!ENABLE) begin
      state_nxt = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE:  if (fall) state_nxt = S_START;
        S_START: if (rise) state_nxt = S_IDLE;
                 else if (lo_hit) state_nxt = S_ACK;
        S_ACK:   if (rise) state_nxt = S_SHIFT;
        S_SHIFT: if (lo_hit) state_nxt = S_ACK;
                 else if (hi_hit) state_nxt = S_IDLE;
                 else if (rise && bit_idx == LAST_BIT) state_nxt = S_DONE;
        S_DONE:  state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    data_nxt = data_q;
    if (!ENABLE) begin
      data_nxt = 1'b1;
    end else begin
      unique case (state)
        S_START: if (lo_hit) data_nxt = 1'b0;
        S_ACK:   if (rise) data_nxt = 1'b1;
        S_SHIFT: if (lo_hit) data_nxt = 1'b0;
                 else if (hi_hit) data_nxt = 1'b1;
                 else if (rise && bit_idx == LAST_BIT) data_nxt = 1'b1;
                 else if (fall) data_nxt = shreg[111];
        default: data_nxt = 1'b1;
      endcase
    end
  end

  assign load  = ENABLE & (state == S_ACK) & rise;
  assign shift = ENABLE & (state == S_SHIFT) & rise;

  always_ff @(posedge CLK_50M or negedge rst_n_i)
    if (!rst_n_i) begin
      data_q  <= 1'b1;
      abort_q <= 1'b0;
      shreg   <= '0;
      bit_idx <= '0;
    end else begin
      data_q  <= data_nxt;
      abort_q <= ENABLE & (state == S_SHIFT) & (lo_hit | hi_hit);
      if (load) begin
        shreg   <= {DEV_TYPE, DEV_BUTTONS, DEV_ANALOG};
        bit_idx <= '0;
      end else if (shift) begin
        shreg <= {shreg[110:0], 1'b0};
        if (bit_idx != LAST_BIT) bit_idx <= bit_idx + 7'd1;
      end
    end

  always_comb begin
    IO_DATA_OUT = data_q;
    ACTIVE      = (state == S_ACK) || (state == S_SHIFT) || (state == S_DONE);
    FRAME_DONE  = (state == S_DONE);
    FRAME_ABORT = abort_q;
  end
endmodule

// File: tb/tb_llapi_device.sv
// tb_llapi_device: directed bench for the LLAPI responder; a queue holds the expected
// frame bits pushed at each poll start and popped at every host sampling point.
module tb_llapi_device;
  localparam int START_MIN = 100;
  localparam int TIMEOUT   = 5000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b1;
  logic        latch = 1'b1;
  logic [7:0]  dev_type = 8'h05;
  logic [31:0] dev_buttons = 32'h8000_0001;
  logic [71:0] dev_analog = 72'h0;
  logic        io_data_out, active, frame_done, frame_abort;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int abort_cnt = 0;
  int d0, a0;
  logic         exp_q[$];
  logic [111:0] cur_frame;
  logic         saw_low;

  llapi_device #(.START_MIN(START_MIN), .TIMEOUT(TIMEOUT)) dut (
    .CLK_50M(clk), .RST_N(rst_n), .ENABLE(enable), .IO_LATCH_IN(latch),
    .IO_DATA_OUT(io_data_out), .DEV_TYPE(dev_type), .DEV_BUTTONS(dev_buttons),
    .DEV_ANALOG(dev_analog), .ACTIVE(active), .FRAME_DONE(frame_done),
    .FRAME_ABORT(frame_abort)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_done)  done_cnt++;
    if (frame_abort) abort_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame();
    cur_frame = {dev_type, dev_buttons, dev_analog};
    for (int k = 0; k < 112; k++) exp_q.push_back(cur_frame[111-k]);
  endtask

  task automatic do_start(input bit check_early);
    latch = 1'b0;
    tick(START_MIN + 1);
    if (check_early) check("ack_early", io_data_out, 1);
    tick(1);
    check("ack_low", io_data_out, 0);
    check("ack_active", active, 1);
    tick(3);
    latch = 1'b1;
    push_frame();
    tick(20);
    check("ack_release", io_data_out, 1);
  endtask

  task automatic shift_bits(input int n);
    logic e;
    for (int i = 0; i < n; i++) begin
      latch = 1'b0;
      tick(20);
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL sb_empty observed=%0d expected=nonzero", exp_q.size());
      end
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 1'bx;
      check($sformatf("bit%0d", i), io_data_out, e);
      latch = 1'b1;
      tick(20);
    end
  endtask

  task automatic full_frame(input string tag);
    d0 = done_cnt;
    a0 = abort_cnt;
    do_start(1);
    shift_bits(112);
    check({tag, "_done"}, done_cnt - d0, 1);
    check({tag, "_noabort"}, abort_cnt - a0, 0);
    check({tag, "_idle"}, active, 0);
    check({tag, "_sb_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    // Reset with latch toggling
    tick(2);
    for (int i = 0; i < 8; i++) begin
      latch = ~latch;
      tick(1);
      check("rst_data", io_data_out, 1);
      check("rst_active", active, 0);
    end
    latch = 1'b1;
    rst_n = 1'b1;
    tick(30);
    check("idle_data", io_data_out, 1);
    check("idle_active", active, 0);

    full_frame("frameA");
    dev_analog = 72'h80_0000_0000_0000_0000;
    full_frame("frameB");

    // Short low pulse must be rejected
    saw_low = 1'b0;
    latch = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick(1);
      if (io_data_out !== 1'b1) saw_low = 1'b1;
    end
    latch = 1'b1;
    tick(20);
    check("glitch_no_ack", saw_low, 0);
    check("glitch_inactive", active, 0);

    // Timeout after 40 bits
    a0 = abort_cnt;
    d0 = done_cnt;
    do_start(1);
    shift_bits(40);
    exp_q.delete();
    tick(TIMEOUT + 100);
    check("tmo_abort", abort_cnt - a0, 1);
    check("tmo_data", io_data_out, 1);
    check("tmo_active", active, 0);
    check("tmo_nodone", done_cnt - d0, 0);
    full_frame("after_tmo");

    // Mid-frame restart with buttons changed after bit 10
    dev_buttons = 32'hA5A5_0F0F;
    a0 = abort_cnt;
    do_start(1);
    shift_bits(10);
    dev_buttons = 32'h5A5A_F0F0;
    shift_bits(40);
    exp_q.delete();
    d0 = done_cnt;
    do_start(0);
    check("restart_abort", abort_cnt - a0, 1);
    check("restart_new_btn", cur_frame[103:72], 32'h5A5A_F0F0);
    shift_bits(112);
    check("restart_done", done_cnt - d0, 1);

    // ENABLE drop at bit 30
    dev_buttons = 32'h8000_0001;
    dev_analog = 72'h0;
    d0 = done_cnt;
    a0 = abort_cnt;
    do_start(1);
    shift_bits(30);
    latch = 1'b0;
    tick(10);
    check("en_bit30", io_data_out, cur_frame[111-30]);
    enable = 1'b0;
    tick(1);
    check("en_release", io_data_out, 1);
    check("en_inactive", active, 0);
    tick(9);
    latch = 1'b1;
    tick(20);
    exp_q.delete();
    latch = 1'b0;
    tick(20);
    enable = 1'b1;
    tick(150);
    check("reen_no_ack", io_data_out, 1);
    check("reen_inactive", active, 0);
    latch = 1'b1;
    tick(20);
    check("en_nodone", done_cnt - d0, 0);
    check("en_noabort", abort_cnt - a0, 0);

    // Async reset mid-shift
    do_start(1);
    shift_bits(20);
    latch = 1'b0;
    tick(10);
    check("ar_bit20", io_data_out, cur_frame[111-20]);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_data", io_data_out, 1);
    check("ar_active", active, 0);
    check("ar_done", frame_done, 0);
    check("ar_abort", frame_abort, 0);
    latch = 1'b1;
    tick(5);
    rst_n = 1'b1;
    tick(10);
    exp_q.delete();
    full_frame("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
